// File: rtl/iob_f2s_event_sched.sv
// iob_f2s_event_sched: slow-domain scheduler for a bank of synchronized event levels.
// Rising edges on enabled inputs latch pending flags. The pending flags are arbitrated,
// round-robin by default, onto a single valid/ready port that carries the event index.
// Edges that hit an already-pending flag are lost, and a saturating counter tallies them.
//
// Optional build macro:
//   IOB_F2S_EVSCHED_FIXED_PRIO_EN - fixed priority (lowest pending index wins), no pointer.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (overrides cke_i)
//   cke_i       clock enable; low freezes all state and ignores the handshake
//   sync_i      synchronized event levels
//   en_i        per-event enable mask (gates new edges only)
//   ev_valid_o  event offered
//   ev_ready_i  consumer accepts the event
//   ev_idx_o    index of the offered event
//   pending_o   pending flags
//   ovf_cnt_o   saturating lost-event count
//   clr_ovf_i   clear overflow counter (wins over a same-cycle increment)
module iob_f2s_event_sched #(
    parameter int unsigned N_EVENTS = 4,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned IDX_W   = $clog2(N_EVENTS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic [N_EVENTS-1:0] sync_i,
    input  logic [N_EVENTS-1:0] en_i,
    output logic                ev_valid_o,
    input  logic                ev_ready_i,
    output logic [IDX_W-1:0]    ev_idx_o,
    output logic [N_EVENTS-1:0] pending_o,
    output logic [CNT_W-1:0]    ovf_cnt_o,
    input  logic                clr_ovf_i
);

    localparam int unsigned SUM_W = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e              state_q, state_d;
    logic [N_EVENTS-1:0] prev_q, pending_q, pending_d;
    logic [N_EVENTS-1:0] edge_det, clr_mask, ovf_bits;
    logic [IDX_W-1:0]    idx_q, idx_d, sel_idx;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [5:0]          ovf_pop;
    logic [SUM_W-1:0]    cnt_sum;
    logic                handshake;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_EVENTS-1:0] v);
        lowest_idx = '0;
        for (int i = N_EVENTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

`ifdef IOB_F2S_EVSCHED_FIXED_PRIO_EN
    always_comb begin
        sel_idx = lowest_idx(pending_q);
    end
`else
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [N_EVENTS-1:0] ge_mask, upper;

    // Search from the pointer upward first; if nothing is pending there, wrap to bit 0.
    always_comb begin
        ge_mask = ~((N_EVENTS'(1) << ptr_q) - N_EVENTS'(1));
        upper   = pending_q & ge_mask;
        sel_idx = (upper != '0) ? lowest_idx(upper) : lowest_idx(pending_q);
    end
`endif

    always_comb begin
        handshake = (state_q == StOffer) & ev_ready_i & cke_i;
        edge_det  = sync_i & ~prev_q & en_i;
        clr_mask  = handshake ? (N_EVENTS'(1) << idx_q) : '0;
        // A new edge on a bit cleared this cycle is retained, not counted as lost.
        ovf_bits  = edge_det & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | edge_det;

        ovf_pop = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            ovf_pop = ovf_pop + 6'(ovf_bits[i]);
        end
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(ovf_pop);
        if (clr_ovf_i) begin
            cnt_d = '0;
        end else if (cnt_sum > SUM_W'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end

        state_d = state_q;
        idx_d   = idx_q;
`ifndef IOB_F2S_EVSCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Registered pending only; same-cycle edges are seen next cycle.
                if (pending_q != '0) begin
                    idx_d   = sel_idx;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (handshake) begin
                    state_d = StIdle;
`ifndef IOB_F2S_EVSCHED_FIXED_PRIO_EN
                    ptr_d   = (idx_q == IDX_W'(N_EVENTS - 1)) ? '0 : idx_q + IDX_W'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            // All ones so that levels already high out of reset produce no event.
            prev_q    <= '1;
            pending_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
`ifndef IOB_F2S_EVSCHED_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else if (cke_i) begin
            state_q   <= state_d;
            prev_q    <= sync_i;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
`ifndef IOB_F2S_EVSCHED_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign ev_valid_o = (state_q == StOffer);
    assign ev_idx_o   = idx_q;
    assign pending_o  = pending_q;
    assign ovf_cnt_o  = cnt_q;

endmodule
